// File: rtl/nand_reduce_fifo.sv
// nand_reduce_fifo: registered multi-input bitwise reduction (NAND/AND/NOR/OR)
// with a per-operand mask. Results are buffered in a DEPTH-entry FIFO, with
// valid/ready handshakes on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand transaction valid
//   in_ready   unit can accept a transaction this cycle
//   in_data    packed operands; operand i = in_data[i*WIDTH +: WIDTH]
//   in_mask    1 = operand participates, 0 = replaced by the mode identity
//   in_mode    0 NAND, 1 AND, 2 NOR, 3 OR
//   out_valid  FIFO head holds a result
//   out_ready  downstream accepts the head this cycle
//   out_data   FIFO head result (0 when empty)
//   out_count  current FIFO occupancy
module nand_reduce_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_mask,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] out_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  // Holds in_ready low until the first clock edge after reset release.
  logic             init_q;

  logic [WIDTH-1:0] acc_and, acc_or, result;
  logic             push, pop;

  // Masked operands are simply skipped, which equals substituting the identity.
  always_comb begin
    acc_and = '1;
    acc_or  = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (in_mask[i]) begin
        acc_and = acc_and & in_data[i*WIDTH +: WIDTH];
        acc_or  = acc_or  | in_data[i*WIDTH +: WIDTH];
      end
    end
    unique case (in_mode)
      2'd0:    result = ~acc_and;
      2'd1:    result = acc_and;
      2'd2:    result = ~acc_or;
      default: result = acc_or;
    endcase
  end

  assign in_ready  = init_q && (count_q < CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_count = count_q;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      init_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      init_q   <= 1'b1;
    end
  end

  // Storage is not reset; out_data is gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= result;
    end
  end

endmodule

// File: tb/tb_nand_reduce_fifo.sv
module tb_nand_reduce_fifo;

  localparam int W = 8;
  localparam int N = 4;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_mask;
  logic [1:0]     in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_count;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] sb_q[$];
  bit started = 1'b0;

  always #5 clk = ~clk;

  nand_reduce_fifo #(.WIDTH(W), .NUM_IN(N), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [N*W-1:0] d, input logic [N-1:0] m,
                                         input logic [1:0] md);
    logic [W-1:0] a, o;
    a = '1;
    o = '0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        a = a & d[i*W +: W];
        o = o | d[i*W +: W];
      end
    end
    case (md)
      2'd0: return ~a;
      2'd1: return a;
      2'd2: return ~o;
      default: return o;
    endcase
  endfunction

  // Called at a falling edge with inputs already driven; checks state, then
  // updates the scoreboard for the coming rising edge.
  task automatic tick();
    bit exp_ready, exp_valid;
    logic [W-1:0] exp_data;
    exp_ready = started && (sb_q.size() < D);
    exp_valid = (sb_q.size() != 0);
    check_val("in_ready", in_ready, exp_ready);
    check_val("out_valid", out_valid, exp_valid);
    check_val("out_count", out_count, sb_q.size());
    if (!exp_valid) check_val("out_data_empty", out_data, 0);
    if (exp_valid && out_ready) begin
      exp_data = sb_q.pop_front();
      check_val("out_data", out_data, exp_data);
    end
    if (exp_ready && in_valid) sb_q.push_back(model(in_data, in_mask, in_mode));
    @(negedge clk);
    started = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [N*W-1:0] d, input logic [N-1:0] m,
                       input logic [1:0] md, input logic r);
    in_valid  = v;
    in_data   = d;
    in_mask   = m;
    in_mode   = md;
    out_ready = r;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb_q.size() != 0; i++) begin
      drive(1'b0, 'x, '0, 2'd0, 1'b1);
      tick();
    end
    check_val("drained", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_count", out_count, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_in_ready", in_ready, 0);
    sb_q.delete();
    started = 1'b0;
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_in_ready", in_ready, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    #1;
    check_val("init_out_valid", out_valid, 0);
    check_val("init_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic NAND then pop.
    drive(1'b1, {8'hF0, 8'h0F, 8'hFF, 8'hFF}, 4'b1111, 2'd0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    check_val("first_result", out_data, 8'hFF);
    out_ready = 1'b1;
    tick();
    tick();

    // All four modes back-to-back.
    for (int md = 0; md < 4; md++) begin
      drive(1'b1, {8'h3C, 8'hFF, 8'hFF, 8'hFF}, 4'b1111, md[1:0], 1'b1);
      tick();
    end
    drain();

    // Mask and identity.
    drive(1'b1, {8'h00, 8'h00, 8'h00, 8'hA5}, 4'b0001, 2'd0, 1'b1);
    tick();
    for (int md = 0; md < 4; md++) begin
      drive(1'b1, {8'h12, 8'h34, 8'h56, 8'h78}, 4'b0000, md[1:0], 1'b1);
      tick();
    end
    drain();

    // Backpressure: fill, hold a third, pop one, third goes in after.
    drive(1'b1, {8'h11, 8'hFF, 8'hFF, 8'hFF}, 4'b1111, 2'd1, 1'b0);
    tick();
    drive(1'b1, {8'h22, 8'hFF, 8'hFF, 8'hFF}, 4'b1111, 2'd1, 1'b0);
    tick();
    drive(1'b1, {8'h33, 8'hFF, 8'hFF, 8'hFF}, 4'b1111, 2'd1, 1'b0);
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    drain();

    // Simultaneous push/pop at occupancy 1 with pointer wrap.
    drive(1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h00}, 4'b1111, 2'd1, 1'b0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, {8'hFF, 8'hFF, 8'hFF, 8'(i)}, 4'b1111, 2'd1, 1'b1);
      tick();
    end
    drain();

    // Randomised traffic, X operands while idle.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, 'x, 'x, 2'($urandom), 1'($urandom));
      else drive(1'b1, {$urandom}, 4'($urandom), 2'($urandom), 1'($urandom));
      tick();
    end
    drain();

    // Asynchronous reset with two entries buffered.
    drive(1'b1, {8'h5A, 8'hFF, 8'hFF, 8'hFF}, 4'b1111, 2'd3, 1'b0);
    tick();
    tick();
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    check_val("full_count", out_count, 2);
    do_reset();
    tick();
    drive(1'b1, {8'h00, 8'h00, 8'h00, 8'h0F}, 4'b0001, 2'd2, 1'b1);
    tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nand_reduce_fifo.md
Name: nand_reduce_fifo

Overview:
Parametrised, registered multi-input bitwise logic reduction unit, the clocked successor to the single 2-input NAND cell in the ece555_final library. It reduces NUM_IN operand words of WIDTH bits through a selectable mode (NAND/AND/NOR/OR) with a per-operand mask. Results are buffered in a DEPTH-entry FIFO behind a valid/ready handshake on both sides, so it can sit between pipelined datapath stages of the final project.

Parameters:
WIDTH, 8, bits per operand word and per result
NUM_IN, 4, number of operand words reduced per transaction (>=2)
DEPTH, 2, result FIFO entries (>=1; power of two not required)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transaction valid
in_ready  output  1  unit can accept a transaction this cycle
in_data  input  NUM_IN*WIDTH  packed operands; operand i = in_data[i*WIDTH +: WIDTH]
in_mask  input  NUM_IN  1 = operand i participates; 0 = replaced by mode identity
in_mode  input  2  0 NAND, 1 AND, 2 NOR, 3 OR
out_valid  output  1  FIFO head holds a result
out_ready  input  1  downstream accepts head this cycle
out_data  output  WIDTH  FIFO head result
out_count  output  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous, no clk needed): FIFO emptied, read/write pointers 0, out_count=0, out_valid=0, out_data=0, in_ready=0 while rst_n low; in_ready=1 from the first clk edge after release. Storage contents not required to reset, but out_data must read 0 whenever out_valid=0.
- Reduction (combinational, evaluated on the accepting edge):
  - AND-family (modes 0,1): acc = bitwise AND of operands with mask=1; masked operands count as all-ones. Mode 0 result = ~acc, mode 1 result = acc.
  - OR-family (modes 2,3): acc = bitwise OR of operands with mask=1; masked operands count as all-zeros. Mode 2 result = ~acc, mode 3 result = acc.
  - All masks 0: acc = identity, so NAND -> all 0, AND -> all 1, NOR -> all 1, OR -> all 0.
- Accept: transfer when in_valid && in_ready at a rising edge; the result is written at the write pointer.
- in_ready = (out_count < DEPTH). It is registered-state only, with no combinational path from out_ready.
- Pop: when out_valid && out_ready at a rising edge, the read pointer advances.
- out_valid = (out_count != 0); out_data = entry at the read pointer (0 when empty).
- Latency: a result accepted at edge k is visible on out_data/out_valid after edge k, i.e. 1 cycle. Throughput is 1 per cycle when not full.
- Simultaneous push and pop in the same edge: both occur and out_count is unchanged. This is legal at any occupancy below DEPTH.
- Full (out_count=DEPTH): in_ready=0, so no push. A pop that edge brings the count to DEPTH-1 and raises in_ready next cycle. Upstream must hold in_data/in_mask/in_mode stable while in_valid=1 && in_ready=0.
- Pointer wrap: each pointer goes DEPTH-1 -> 0. Ordering is strictly FIFO.
- in_valid while in_ready=0: ignored, no state change.
- out_ready while empty: ignored; pointers and count are unchanged, never negative.
- rst_n assertion mid-operation: all buffered results are discarded immediately. out_valid drops asynchronously.
- X on in_data with in_valid=0 must not propagate into state.

Test Plan:
- Reset, then in_data={F0,0F,FF,FF} (op3..op0), mask=1111, mode=0 -> one cycle later out_valid=1, out_data=FF. Pop -> out_count=0, out_valid=0, out_data=00.
- Operands {3C,FF,FF,FF}, mask=1111, modes 0,1,2,3 back-to-back with out_ready=1 -> outputs C3, 3C, 00, FF in order, one per cycle.
- Mask and identity checks:
  - op0=A5, others 00, mask=0001, mode 0 -> 5A.
  - mask=0000 in modes 0,1,2,3 -> 00, FF, FF, 00.
- Backpressure (DEPTH=2):
  - out_ready=0, push results R1, R2 -> in_ready=0, out_count=2; a third in_valid is held.
  - Raise out_ready one cycle -> R1 pops, R3 is accepted the next cycle.
  - Drain order is R1, R2, R3.
- Simultaneous push/pop at out_count=1 for 10 cycles with an incrementing op0 (others FF, mask=1111, mode 1) -> out_count stays 1. Outputs equal inputs delayed by one entry, and the pointers wrap correctly.
- Assert rst_n low asynchronously mid-clock with out_count=2 -> out_valid, out_count and out_data go to 0 without a clock edge. in_ready is 0 until the first edge after release.
